// File: rtl/lab3_pkg.sv
// Shared definitions for the lab-3 detector back end: FSM encodings and counter width helper.
package lab3_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT
  } state_e;

  // Width needed to count 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lab3_shift_reg.sv
// Shift-in register with bit counter; word_done_o is combinational so the
// consumer can capture word_o on the same edge the last bit is accepted.
module lab3_shift_reg
  import lab3_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CW        = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_done_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    if (MSB_FIRST != 0) begin
      word_o = {sr_q[WIDTH-2:0], bit_i};
    end else begin
      // LSB-first: bits enter at the top and walk down to bit 0.
      word_o = {bit_i, sr_q[WIDTH-1:1]};
    end
    word_done_o = shift_i && (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      if (word_done_o) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = word_o;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/serial_word_collector.sv
// Packs detector bits into WIDTH-bit words behind a one-entry valid/ready register.
// Optional ones_count output enabled by LAB3_ONES_COUNT_EN.
module serial_word_collector
  import lab3_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    bit_count,
`ifdef LAB3_ONES_COUNT_EN
  output logic [CW-1:0]    ones_count,
`endif
  output logic             overflow
);

  logic             accept;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             xfer;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  assign accept = bit_valid && !clear;

  lab3_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_shift (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (clear),
    .shift_i     (accept),
    .bit_i       (bit_in),
    .word_o      (word),
    .word_done_o (word_done),
    .count_o     (bit_count)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE:  state_d = ST_SHIFT;
        ST_SHIFT: state_d = word_done ? ST_IDLE : ST_SHIFT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // A full register may still take a new word if it drains on the same edge.
  assign xfer = valid_q && out_ready;
  assign load = word_done && (!valid_q || out_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clear) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
      end
      if (load) begin
        valid_d = 1'b1;
        data_d  = word;
      end else if (word_done) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overflow  = ovf_q;

`ifdef LAB3_ONES_COUNT_EN
  logic [CW-1:0] word_ones;
  logic [CW-1:0] ones_q, ones_d;

  always_comb begin
    word_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_ones = word_ones + CW'(word[i]);
    end
  end

  always_comb begin
    ones_d = ones_q;
    if (clear) begin
      ones_d = '0;
    end else if (load) begin
      ones_d = word_ones;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a queue-based word model.
module tb_serial_word_collector;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;

  logic          v0, v1, o0, o1;
  logic [W-1:0]  d0, d1;
  logic [CW-1:0] c0, c1;
`ifdef LAB3_ONES_COUNT_EN
  logic [CW-1:0] n0, n1;
`endif

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(0)) u0 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .out_ready(out_ready), .out_valid(v0), .out_data(d0),
    .bit_count(c0),
`ifdef LAB3_ONES_COUNT_EN
    .ones_count(n0),
`endif
    .overflow(o0));

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1)) u1 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .out_ready(out_ready), .out_valid(v1), .out_data(d1),
    .bit_count(c1),
`ifdef LAB3_ONES_COUNT_EN
    .ones_count(n1),
`endif
    .overflow(o1));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: pending bits in arrival order; a word is formed when W bits are held.
  bit           pq[$];
  logic         m_valid, m_ovf;
  logic [W-1:0] m_d0, m_d1;
  logic [CW-1:0] m_ones;

  always @(posedge clock or negedge reset) begin
    logic was_valid, loaded;
    logic [W-1:0] w0, w1;
    if (!reset) begin
      pq.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_d0 = '0; m_d1 = '0; m_ones = '0;
    end else if (clear) begin
      pq.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_ones = '0;
    end else begin
      was_valid = m_valid;
      loaded = 1'b0;
      if (bit_valid) begin
        pq.push_back(bit_in);
        if (pq.size() == W) begin
          w0 = '0; w1 = '0;
          for (int i = 0; i < W; i++) begin
            w0[i]       = pq[i];
            w1[W-1-i]   = pq[i];
          end
          pq.delete();
          if (!was_valid || out_ready) begin
            m_d0 = w0; m_d1 = w1; m_valid = 1'b1; loaded = 1'b1;
            m_ones = CW'($countones(w0));
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (!loaded && was_valid && out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (reset && cmp_en) begin
      chk("valid0", 32'(v0), 32'(m_valid));
      chk("valid1", 32'(v1), 32'(m_valid));
      chk("data0", 32'(d0), 32'(m_d0));
      chk("data1", 32'(d1), 32'(m_d1));
      chk("count0", 32'(c0), pq.size());
      chk("count1", 32'(c1), pq.size());
      chk("ovf0", 32'(o0), 32'(m_ovf));
      chk("ovf1", 32'(o1), 32'(m_ovf));
`ifdef LAB3_ONES_COUNT_EN
      chk("ones0", 32'(n0), 32'(m_ones));
`endif
    end
  end

  task automatic put(input logic b, input logic v, input logic c);
    @(posedge clock);
    #2;
    bit_in = b; bit_valid = v; clear = c;
  endtask

  task automatic put_byte(input logic [7:0] val);
    logic [7:0] t;
    t = val;
    for (int i = 0; i < 8; i++) put(t[i], 1'b1, 1'b0);
  endtask

  initial begin
    int npulse;
    int pos[$];
    #1;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_ovf", 32'(o0), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    // Single word, both bit orders
    out_ready = 1'b1;
    put_byte(8'h4D);
    put(0, 0, 0);
    chk("t1_valid", 32'(v0), 32'd1);
    chk("t1_lsb", 32'(d0), 32'h4D);
    chk("t1_msb", 32'(d1), 32'hB2);
    chk("t1_ovf", 32'(o0), 32'd0);
`ifdef LAB3_ONES_COUNT_EN
    chk("t1_ones", 32'(n0), 32'd4);
`endif
    put(0, 0, 0);
    chk("t1_drain", 32'(v0), 32'd0);

    // Back-pressure: second word dropped
    out_ready = 1'b0;
    put_byte(8'h4D);
    put_byte(8'hFF);
    put(0, 0, 0);
    chk("t3_hold", 32'(d0), 32'h4D);
    chk("t3_ovf", 32'(o0), 32'd1);
    out_ready = 1'b1;
    put(0, 0, 0);
    out_ready = 1'b0;
    chk("t3_xfer", 32'(v0), 32'd0);
    chk("t3_sticky", 32'(o0), 32'd1);
    put(0, 0, 1);
    put(0, 0, 0);
    chk("t3_clr_ovf", 32'(o0), 32'd0);

    // Back-to-back words
    out_ready = 1'b1;
    npulse = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 24) put(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      else put(0, 0, 0);
      if (v0) begin
        npulse++;
        pos.push_back(i);
      end
    end
    chk("t4_pulses", npulse, 32'd3);
    if (pos.size() == 3) begin
      chk("t4_gap1", pos[1] - pos[0], 32'd8);
      chk("t4_gap2", pos[2] - pos[1], 32'd8);
    end
    chk("t4_ovf", 32'(o0), 32'd0);

    // Clear mid-word discards its own bit
    out_ready = 1'b0;
    put(1, 1, 0); put(1, 1, 0); put(1, 1, 0);
    put(1, 1, 1);
    put(0, 0, 0);
    chk("t5_count", 32'(c0), 32'd0);
    chk("t5_valid", 32'(v0), 32'd0);
    chk("t5_ovf", 32'(o0), 32'd0);
    put_byte(8'h96);
    put(0, 0, 0);
    chk("t5_lsb", 32'(d0), 32'h96);
    chk("t5_msb", 32'(d1), 32'h69);

    // Asynchronous reset with a held word and a partial word
    for (int i = 0; i < 5; i++) put(1, 1, 0);
    put(0, 0, 0);
    chk("t6_pre_count", 32'(c0), 32'd5);
    chk("t6_pre_valid", 32'(v0), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(v0), 32'd0);
    chk("t6_data", 32'(d0), 32'd0);
    chk("t6_count", 32'(c0), 32'd0);
    chk("t6_ovf", 32'(o0), 32'd0);
`ifdef LAB3_ONES_COUNT_EN
    chk("t6_ones", 32'(n0), 32'd0);
`endif
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (3) put(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
